// File: rtl/skid_buffer.sv
// skid_buffer: two-entry elastic pipeline register with valid/ready handshakes.
//   Upstream sees a registered ready and downstream sees registered valid/data,
//   so there is no combinational path from outp_ready to inp_ready. Sustains one
//   word per cycle while downstream keeps outp_ready high.
//
// Optional feature macro: SKID_BUFFER_COUNT_EN (adds occupancy port count).
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   inp_valid  upstream word valid
//   inp_ready  buffer can accept (registered)
//   inp        upstream data [WIDTH-1:0]
//   outp_valid downstream word valid (registered)
//   outp_ready downstream accepts
//   outp       downstream data [WIDTH-1:0] (registered)
//   count      occupancy 0..2 (only with SKID_BUFFER_COUNT_EN)
module skid_buffer #(
  parameter int WIDTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inp_valid,
  output logic             inp_ready,
  input  logic [WIDTH-1:0] inp,
  output logic             outp_valid,
  input  logic             outp_ready,
  output logic [WIDTH-1:0] outp
`ifdef SKID_BUFFER_COUNT_EN
  ,
  output logic [1:0]       count
`endif
);

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    BUSY  = 2'd1,
    FULL  = 2'd2
  } state_t;

  state_t           r_state;
  logic [WIDTH-1:0] r_main;
  logic [WIDTH-1:0] r_skid;
  logic             r_outp_valid;
  logic             r_inp_ready;

  logic w_in_fire;
  logic w_out_fire;

  assign w_in_fire  = inp_valid & r_inp_ready;
  assign w_out_fire = r_outp_valid & outp_ready;

  assign inp_ready  = r_inp_ready;
  assign outp_valid = r_outp_valid;
  assign outp       = r_main;

`ifdef SKID_BUFFER_COUNT_EN
  logic [1:0] r_count;
  assign count = r_count;
`endif

  // inp_ready is the registered image of (next state != FULL). It comes up
  // low in reset and rises on the first edge after release, from EMPTY.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state      <= EMPTY;
      r_main       <= '0;
      r_skid       <= '0;
      r_outp_valid <= 1'b0;
      r_inp_ready  <= 1'b0;
`ifdef SKID_BUFFER_COUNT_EN
      r_count      <= 2'd0;
`endif
    end else begin
      case (r_state)
        EMPTY: begin
          r_inp_ready <= 1'b1;
          if (w_in_fire) begin
            r_main       <= inp;
            r_outp_valid <= 1'b1;
            r_state      <= BUSY;
`ifdef SKID_BUFFER_COUNT_EN
            r_count      <= 2'd1;
`endif
          end
        end
        BUSY: begin
          if (w_in_fire && w_out_fire) begin
            r_main <= inp;
          end else if (w_in_fire) begin
            // Downstream stalled: park the new word behind main.
            r_skid      <= inp;
            r_inp_ready <= 1'b0;
            r_state     <= FULL;
`ifdef SKID_BUFFER_COUNT_EN
            r_count     <= 2'd2;
`endif
          end else if (w_out_fire) begin
            r_outp_valid <= 1'b0;
            r_state      <= EMPTY;
`ifdef SKID_BUFFER_COUNT_EN
            r_count      <= 2'd0;
`endif
          end
        end
        FULL: begin
          // inp_ready is low here, so only the drain side can move.
          if (w_out_fire) begin
            r_main      <= r_skid;
            r_inp_ready <= 1'b1;
            r_state     <= BUSY;
`ifdef SKID_BUFFER_COUNT_EN
            r_count     <= 2'd1;
`endif
          end
        end
        default: begin
          r_state      <= EMPTY;
          r_outp_valid <= 1'b0;
          r_inp_ready  <= 1'b0;
`ifdef SKID_BUFFER_COUNT_EN
          r_count      <= 2'd0;
`endif
        end
      endcase
    end
  end

endmodule
